rename_map: RTL and testbench

- 4-wide register rename table for the out-of-order core: 32 architectural registers mapped onto 64 physical registers.
- Sits directly upstream of free_list and is its only client:
  - drives free_list's request count and consumes the physical tags free_list presents;
  - on commit, drives free_list's return count and return tags with the superseded committed mappings.
- Holds a speculative map and a committed map; flush restores speculative from committed.

---
 rtl/rename_map_if.sv | 49 ++++
 rtl/rename_map.sv | 194 +++++++++++++++++++
 tb/tb_rename_map.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_map_if.sv
// rename_map_if: bundles the rename, free-list and commit buses of the
// rename table. The slave modport is the rename table itself and the
// master modport is whatever drives it (decode/ROB/free_list side or a bench).
//   rename group : i_ren_count, i_rs1, i_rs2, i_rd, i_rd_we
//   free list    : i_free_p, i_free_avail, o_req_count, o_ret_count, o_ret_p
//   rename result: o_stall, o_valid_count, o_ps1, o_ps2, o_pd, o_old_pd
//   commit       : i_cmt_count, i_cmt_rd, i_cmt_pd, i_cmt_we
//   recovery     : i_flush
interface rename_map_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned AREG_W = 5,
  parameter int unsigned PREG_W = 6
);
  logic [2:0]              i_ren_count;
  logic [LANES*AREG_W-1:0] i_rs1;
  logic [LANES*AREG_W-1:0] i_rs2;
  logic [LANES*AREG_W-1:0] i_rd;
  logic [LANES-1:0]        i_rd_we;
  logic [LANES*PREG_W-1:0] i_free_p;
  logic [PREG_W:0]         i_free_avail;
  logic [2:0]              o_req_count;
  logic                    o_stall;
  logic [2:0]              o_valid_count;
  logic [LANES*PREG_W-1:0] o_ps1;
  logic [LANES*PREG_W-1:0] o_ps2;
  logic [LANES*PREG_W-1:0] o_pd;
  logic [LANES*PREG_W-1:0] o_old_pd;
  logic [2:0]              i_cmt_count;
  logic [LANES*AREG_W-1:0] i_cmt_rd;
  logic [LANES*PREG_W-1:0] i_cmt_pd;
  logic [LANES-1:0]        i_cmt_we;
  logic [2:0]              o_ret_count;
  logic [LANES*PREG_W-1:0] o_ret_p;
  logic                    i_flush;

  modport slave (
    input  i_ren_count, i_rs1, i_rs2, i_rd, i_rd_we, i_free_p, i_free_avail,
           i_cmt_count, i_cmt_rd, i_cmt_pd, i_cmt_we, i_flush,
    output o_req_count, o_stall, o_valid_count, o_ps1, o_ps2, o_pd, o_old_pd,
           o_ret_count, o_ret_p
  );

  modport master (
    output i_ren_count, i_rs1, i_rs2, i_rd, i_rd_we, i_free_p, i_free_avail,
           i_cmt_count, i_cmt_rd, i_cmt_pd, i_cmt_we, i_flush,
    input  o_req_count, o_stall, o_valid_count, o_ps1, o_ps2, o_pd, o_old_pd,
           o_ret_count, o_ret_p
  );
endinterface

// File: rtl/rename_map.sv
// rename_map: 4-wide register rename table, 32 architectural registers onto
// 64 physical tags. Keeps a speculative map (updated at rename) and a
// committed map (updated at commit); flush copies committed into speculative.
// Ports:
//   i_clk  - clock, all state on rising edge
//   i_rst  - synchronous active-high reset (maps to identity, outputs to 0)
//   bus    - rename_map_if.slave: rename group in, free-list request/return,
//            registered rename results, commit group in, flush.
module rename_map #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned AREGS  = 32,
  parameter int unsigned PREG_W = 6
) (
  input logic         i_clk,
  input logic         i_rst,
  rename_map_if.slave bus
);
  localparam int unsigned AREG_W = $clog2(AREGS);
  localparam int unsigned LW     = $clog2(LANES);

  // Map state
  logic [PREG_W-1:0] spec_map_q [AREGS];
  logic [PREG_W-1:0] spec_map_d [AREGS];
  logic [PREG_W-1:0] cmt_map_q  [AREGS];
  logic [PREG_W-1:0] cmt_map_d  [AREGS];

  // Registered outputs
  logic [2:0]              valid_count_q;
  logic [LANES*PREG_W-1:0] ps1_q, ps2_q, pd_q, old_pd_q;
  logic [LANES*PREG_W-1:0] ps1_d, ps2_d, pd_d, old_pd_d;
  logic [2:0]              ret_count_q, ret_count_d;
  logic [LANES*PREG_W-1:0] ret_p_q, ret_p_d;

  // Unpacked lane views
  logic [AREG_W-1:0] rs1 [LANES];
  logic [AREG_W-1:0] rs2 [LANES];
  logic [AREG_W-1:0] rd  [LANES];
  logic [PREG_W-1:0] free_p [LANES];
  logic [AREG_W-1:0] cmt_rd [LANES];
  logic [PREG_W-1:0] cmt_pd [LANES];

  // Rename datapath
  logic [LANES-1:0]  alloc;
  logic [LANES-1:0]  lane_v;
  logic [PREG_W-1:0] pd_a   [LANES];
  logic [PREG_W-1:0] ps1_a  [LANES];
  logic [PREG_W-1:0] ps2_a  [LANES];
  logic [PREG_W-1:0] old_a  [LANES];
  logic [2:0]        need;
  logic              stall;
  logic              accept;

  // Commit datapath
  logic [PREG_W-1:0] ret_a [LANES];

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      rs1[k]    = bus.i_rs1[k*AREG_W +: AREG_W];
      rs2[k]    = bus.i_rs2[k*AREG_W +: AREG_W];
      rd[k]     = bus.i_rd[k*AREG_W +: AREG_W];
      free_p[k] = bus.i_free_p[k*PREG_W +: PREG_W];
      cmt_rd[k] = bus.i_cmt_rd[k*AREG_W +: AREG_W];
      cmt_pd[k] = bus.i_cmt_pd[k*PREG_W +: PREG_W];
    end
  end

  // Allocation: allocating lanes consume free-list entries in lane order.
  always_comb begin
    logic [2:0] n;
    n = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_v[k] = (k < 32'(bus.i_ren_count));
      alloc[k]  = lane_v[k] && bus.i_rd_we[k] && (rd[k] != '0);
      pd_a[k]   = '0;
      if (alloc[k]) begin
        pd_a[k] = free_p[n[LW-1:0]];
        n       = n + 3'd1;
      end
    end
    need = n;
  end

  assign stall  = !i_rst && !bus.i_flush && ({4'd0, need} > bus.i_free_avail);
  assign accept = !i_rst && !bus.i_flush && !stall;

  assign bus.o_stall     = stall;
  assign bus.o_req_count = accept ? need : 3'd0;

  // Source and previous-destination lookup with intra-group bypass: a later
  // matching lane overwrites an earlier one, so the highest earlier lane wins.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      ps1_a[k] = '0;
      ps2_a[k] = '0;
      old_a[k] = '0;
      if (lane_v[k]) begin
        if (rs1[k] != '0) ps1_a[k] = spec_map_q[rs1[k]];
        if (rs2[k] != '0) ps2_a[k] = spec_map_q[rs2[k]];
        if (alloc[k])     old_a[k] = spec_map_q[rd[k]];
        for (int unsigned j = 0; j < k; j++) begin
          if (alloc[j] && rd[j] == rs1[k]) ps1_a[k] = pd_a[j];
          if (alloc[j] && rd[j] == rs2[k]) ps2_a[k] = pd_a[j];
          if (alloc[j] && alloc[k] && rd[j] == rd[k]) old_a[k] = pd_a[j];
        end
      end
    end
    ps1_d    = '0;
    ps2_d    = '0;
    pd_d     = '0;
    old_pd_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      ps1_d[k*PREG_W +: PREG_W]    = ps1_a[k];
      ps2_d[k*PREG_W +: PREG_W]    = ps2_a[k];
      pd_d[k*PREG_W +: PREG_W]     = pd_a[k];
      old_pd_d[k*PREG_W +: PREG_W] = old_a[k];
    end
  end

  // Commit: cmt_map_d is updated lane by lane, so a later lane with the same
  // rd frees the tag written by the earlier lane rather than the stale entry.
  always_comb begin
    logic [2:0] m;
    m         = '0;
    cmt_map_d = cmt_map_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      ret_a[k] = '0;
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      if ((k < 32'(bus.i_cmt_count)) && bus.i_cmt_we[k] && (cmt_rd[k] != '0)) begin
        ret_a[m[LW-1:0]]     = cmt_map_d[cmt_rd[k]];
        cmt_map_d[cmt_rd[k]] = cmt_pd[k];
        m                    = m + 3'd1;
      end
    end
    ret_count_d = m;
    ret_p_d     = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      ret_p_d[k*PREG_W +: PREG_W] = ret_a[k];
    end
  end

  always_comb begin
    spec_map_d = spec_map_q;
    if (bus.i_flush) begin
      spec_map_d = cmt_map_d;
    end else if (accept) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (alloc[k]) spec_map_d[rd[k]] = pd_a[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned a = 0; a < AREGS; a++) begin
        spec_map_q[a] <= PREG_W'(a);
        cmt_map_q[a]  <= PREG_W'(a);
      end
      valid_count_q <= '0;
      ps1_q         <= '0;
      ps2_q         <= '0;
      pd_q          <= '0;
      old_pd_q      <= '0;
      ret_count_q   <= '0;
      ret_p_q       <= '0;
    end else begin
      spec_map_q  <= spec_map_d;
      cmt_map_q   <= cmt_map_d;
      ret_count_q <= ret_count_d;
      ret_p_q     <= ret_p_d;
      if (accept) begin
        valid_count_q <= bus.i_ren_count;
        ps1_q         <= ps1_d;
        ps2_q         <= ps2_d;
        pd_q          <= pd_d;
        old_pd_q      <= old_pd_d;
      end else begin
        valid_count_q <= '0;
        ps1_q         <= '0;
        ps2_q         <= '0;
        pd_q          <= '0;
        old_pd_q      <= '0;
      end
    end
  end

  assign bus.o_valid_count = valid_count_q;
  assign bus.o_ps1         = ps1_q;
  assign bus.o_ps2         = ps2_q;
  assign bus.o_pd          = pd_q;
  assign bus.o_old_pd      = old_pd_q;
  assign bus.o_ret_count   = ret_count_q;
  assign bus.o_ret_p       = ret_p_q;
endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map. Each vector is applied at the falling edge;
// combinational request/stall are checked right away, and the expected
// registered response is queued for the monitor, which pops and compares
// whenever the DUT presents a non-empty rename or return result.
module tb_rename_map;
  logic clk;
  logic rst;

  rename_map_if #(.LANES(4), .AREG_W(5), .PREG_W(6)) bus ();

  rename_map #(.LANES(4), .AREGS(32), .PREG_W(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [2:0]  ren;
    logic [19:0] rs1;
    logic [19:0] rs2;
    logic [19:0] rd;
    logic [3:0]  we;
    logic [23:0] free_p;
    logic [6:0]  avail;
    logic [2:0]  ccnt;
    logic [19:0] crd;
    logic [23:0] cpd;
    logic [3:0]  cwe;
  } vec_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [2:0]  valid;
    logic [23:0] ps1;
    logic [23:0] ps2;
    logic [23:0] pd;
    logic [23:0] old_pd;
    logic [2:0]  ret_count;
    logic [23:0] ret_p;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [19:0] a5(input int x0, input int x1, input int x2, input int x3);
    return {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
  endfunction

  function automatic logic [23:0] p6(input int x0, input int x1, input int x2, input int x3);
    return {6'(x3), 6'(x2), 6'(x1), 6'(x0)};
  endfunction

  function automatic exp_t ez(input int id);
    exp_t e;
    e    = '0;
    e.id = 8'(id);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rst              = v.rst;
    bus.i_flush      = v.flush;
    bus.i_ren_count  = v.ren;
    bus.i_rs1        = v.rs1;
    bus.i_rs2        = v.rs2;
    bus.i_rd         = v.rd;
    bus.i_rd_we      = v.we;
    bus.i_free_p     = v.free_p;
    bus.i_free_avail = v.avail;
    bus.i_cmt_count  = v.ccnt;
    bus.i_cmt_rd     = v.crd;
    bus.i_cmt_pd     = v.cpd;
    bus.i_cmt_we     = v.cwe;
  endtask

  task automatic step(input vec_t v, input logic [2:0] ereq, input logic estall, input exp_t e);
    @(negedge clk);
    apply(v);
    #1;
    chk($sformatf("v%0d_req", e.id), 32'(bus.o_req_count), 32'(ereq));
    chk($sformatf("v%0d_stall", e.id), 32'(bus.o_stall), 32'(estall));
    if (e.valid != 0 || e.ret_count != 0) expq.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},  32'(bus.o_valid_count), 0);
    chk({tag, "_ps1"},    32'(bus.o_ps1), 0);
    chk({tag, "_ps2"},    32'(bus.o_ps2), 0);
    chk({tag, "_pd"},     32'(bus.o_pd), 0);
    chk({tag, "_old_pd"}, 32'(bus.o_old_pd), 0);
    chk({tag, "_ret_cnt"},32'(bus.o_ret_count), 0);
    chk({tag, "_ret_p"},  32'(bus.o_ret_p), 0);
  endtask

  // Monitor: consumes one expectation per non-empty DUT result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_valid_count != 0 || bus.o_ret_count != 0) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", {29'd0, bus.o_valid_count} + {29'd0, bus.o_ret_count}, 0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("v%0d_valid", e.id),   32'(bus.o_valid_count), 32'(e.valid));
          chk($sformatf("v%0d_ps1", e.id),     32'(bus.o_ps1), 32'(e.ps1));
          chk($sformatf("v%0d_ps2", e.id),     32'(bus.o_ps2), 32'(e.ps2));
          chk($sformatf("v%0d_pd", e.id),      32'(bus.o_pd), 32'(e.pd));
          chk($sformatf("v%0d_old_pd", e.id),  32'(bus.o_old_pd), 32'(e.old_pd));
          chk($sformatf("v%0d_ret_cnt", e.id), 32'(bus.o_ret_count), 32'(e.ret_count));
          chk($sformatf("v%0d_ret_p", e.id),   32'(bus.o_ret_p), 32'(e.ret_p));
        end
      end
    end
  end

  initial begin
    vec_t v;
    exp_t e;
    rst = 1'b1;
    apply('{rst: 1'b1, default: '0});

    // Reset with a group that would otherwise stall: no request, no stall.
    v = '0; v.rst = 1; v.ren = 4; v.rd = a5(1, 2, 3, 4); v.we = 4'hf; v.avail = 0;
    step(v, 0, 0, ez(0));
    step(v, 0, 0, ez(0));
    v = '0;
    step(v, 0, 0, ez(0));
    chk_zero("reset");

    // V1: single lane rename.
    v = '0; v.ren = 1; v.rs1 = a5(1,0,0,0); v.rs2 = a5(2,0,0,0); v.rd = a5(3,0,0,0);
    v.we = 4'b0001; v.free_p = p6(32,0,0,0); v.avail = 32;
    e = ez(1); e.valid = 1; e.ps1 = p6(1,0,0,0); e.ps2 = p6(2,0,0,0);
    e.pd = p6(32,0,0,0); e.old_pd = p6(3,0,0,0);
    step(v, 1, 0, e);

    // V2: four lanes all writing r5, sources chase the chain.
    v = '0; v.ren = 4; v.rs1 = a5(5,5,5,5); v.rs2 = a5(3,3,3,3); v.rd = a5(5,5,5,5);
    v.we = 4'hf; v.free_p = p6(32,33,34,35); v.avail = 32;
    e = ez(2); e.valid = 4; e.ps1 = p6(5,32,33,34); e.ps2 = p6(32,32,32,32);
    e.pd = p6(32,33,34,35); e.old_pd = p6(5,32,33,34);
    step(v, 4, 0, e);

    // V3: rd=0 everywhere, nothing allocated; r0 sources read 0.
    v = '0; v.ren = 4; v.rs1 = a5(0,5,0,3); v.rd = a5(0,0,0,0); v.we = 4'hf;
    v.free_p = p6(40,41,42,43); v.avail = 32;
    e = ez(3); e.valid = 4; e.ps1 = p6(0,35,0,32);
    step(v, 0, 0, e);

    // V4: need 3 with 2 available: stall, no output next cycle.
    v = '0; v.ren = 3; v.rs1 = a5(1,1,1,0); v.rd = a5(6,7,8,0); v.we = 4'b0111;
    v.free_p = p6(44,45,46,0); v.avail = 2;
    step(v, 0, 1, ez(4));

    // V5: map untouched by the stalled group.
    v = '0; v.ren = 2; v.rs1 = a5(3,6,0,0); v.rs2 = a5(5,8,0,0); v.avail = 2;
    e = ez(5); e.valid = 2; e.ps1 = p6(32,6,0,0); e.ps2 = p6(35,8,0,0);
    step(v, 0, 0, e);

    // V6: need equals available, intra-group bypass on rs1.
    v = '0; v.ren = 2; v.rs1 = a5(9,9,0,0); v.rs2 = a5(10,0,0,0); v.rd = a5(9,10,0,0);
    v.we = 4'b0011; v.free_p = p6(46,47,0,0); v.avail = 2;
    e = ez(6); e.valid = 2; e.ps1 = p6(9,46,0,0); e.ps2 = p6(10,0,0,0);
    e.pd = p6(46,47,0,0); e.old_pd = p6(9,10,0,0);
    step(v, 2, 0, e);

    // V7: non-allocating lane between two allocating lanes.
    v = '0; v.ren = 3; v.rs1 = a5(11,11,11,0); v.rs2 = a5(12,12,12,0); v.rd = a5(11,12,11,0);
    v.we = 4'b0101; v.free_p = p6(50,51,52,53); v.avail = 10;
    e = ez(7); e.valid = 3; e.ps1 = p6(11,50,50,0); e.ps2 = p6(12,12,12,0);
    e.pd = p6(50,0,51,0); e.old_pd = p6(11,0,50,0);
    step(v, 2, 0, e);

    // V8: commit r3 twice in one group.
    v = '0; v.ccnt = 2; v.crd = a5(3,3,0,0); v.cpd = p6(32,40,0,0); v.cwe = 4'b0011;
    e = ez(8); e.ret_count = 2; e.ret_p = p6(3,32,0,0);
    step(v, 0, 0, e);

    // V9: commit with an r0 lane and a lane beyond the count.
    v = '0; v.ccnt = 3; v.crd = a5(0,5,5,9); v.cpd = p6(60,35,61,62); v.cwe = 4'hf;
    e = ez(9); e.ret_count = 2; e.ret_p = p6(5,35,0,0);
    step(v, 0, 0, e);

    // V10: rename r7 -> 33.
    v = '0; v.ren = 1; v.rs1 = a5(7,0,0,0); v.rd = a5(7,0,0,0); v.we = 4'b0001;
    v.free_p = p6(33,0,0,0); v.avail = 5;
    e = ez(10); e.valid = 1; e.ps1 = p6(7,0,0,0); e.pd = p6(33,0,0,0); e.old_pd = p6(7,0,0,0);
    step(v, 1, 0, e);

    // V11: flush, rename group ignored.
    v = '0; v.flush = 1; v.ren = 1; v.rd = a5(13,0,0,0); v.we = 4'b0001;
    v.free_p = p6(20,0,0,0); v.avail = 10;
    step(v, 0, 0, ez(11));

    // V12: speculative map now equals committed map.
    v = '0; v.ren = 4; v.rs1 = a5(7,3,5,9); v.rs2 = a5(11,10,13,0); v.avail = 10;
    e = ez(12); e.valid = 4; e.ps1 = p6(7,40,61,9); e.ps2 = p6(11,10,13,0);
    step(v, 0, 0, e);

    // V13: flush with a same-cycle commit; would-be stall is suppressed.
    v = '0; v.flush = 1; v.ren = 4; v.rd = a5(1,2,3,4); v.we = 4'hf; v.avail = 0;
    v.ccnt = 1; v.crd = a5(14,0,0,0); v.cpd = p6(55,0,0,0); v.cwe = 4'b0001;
    e = ez(13); e.ret_count = 1; e.ret_p = p6(14,0,0,0);
    step(v, 0, 0, e);

    // V14: flush picked up the same-cycle commit.
    v = '0; v.ren = 1; v.rs1 = a5(14,0,0,0); v.rs2 = a5(3,0,0,0); v.avail = 10;
    e = ez(14); e.valid = 1; e.ps1 = p6(55,0,0,0); e.ps2 = p6(40,0,0,0);
    step(v, 0, 0, e);

    // V15: rename r15, then a stalling group, then reset mid-stall.
    v = '0; v.ren = 1; v.rs1 = a5(15,0,0,0); v.rd = a5(15,0,0,0); v.we = 4'b0001;
    v.free_p = p6(62,0,0,0); v.avail = 4;
    e = ez(15); e.valid = 1; e.ps1 = p6(15,0,0,0); e.pd = p6(62,0,0,0); e.old_pd = p6(15,0,0,0);
    step(v, 1, 0, e);
    v = '0; v.ren = 2; v.rd = a5(15,16,0,0); v.we = 4'b0011; v.free_p = p6(1,2,0,0); v.avail = 1;
    step(v, 0, 1, ez(16));
    v.rst = 1; v.ccnt = 1; v.crd = a5(3,0,0,0); v.cpd = p6(9,0,0,0); v.cwe = 4'b0001;
    step(v, 0, 0, ez(17));
    v = '0;
    step(v, 0, 0, ez(18));
    chk_zero("midreset");

    // V19: both maps back to identity.
    v = '0; v.ren = 4; v.rs1 = a5(3,5,14,15); v.rs2 = a5(7,0,0,0); v.avail = 10;
    v.ccnt = 1; v.crd = a5(3,0,0,0); v.cpd = p6(20,0,0,0); v.cwe = 4'b0001;
    e = ez(19); e.valid = 4; e.ps1 = p6(3,5,14,15); e.ps2 = p6(7,0,0,0);
    e.ret_count = 1; e.ret_p = p6(3,0,0,0);
    step(v, 0, 0, e);

    v = '0;
    for (int i = 0; i < 3; i++) step(v, 0, 0, ez(20));
    chk("queue_drained", 32'(expq.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
